// File: rtl/seq_det_pkg.sv
// Shared types and constants for the serial transmitter slice.
package seq_det_pkg;

    localparam int SER_W = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } t_ser_state;

endpackage

// File: rtl/seq_ser_tx_if.sv
// Byte producer channel: valid/ready handshake carrying one SER_W-bit word.
interface seq_ser_tx_if;
    import seq_det_pkg::*;

    logic [SER_W-1:0] in_data;
    logic             in_valid;
    logic             in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/seq_ser_fifo.sv
// Power-of-two byte FIFO with occupancy count; push ignored when full, pop ignored when empty.
module seq_ser_fifo #(
    parameter int DEPTH = 4,
    parameter int SER_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [SER_W-1:0]       wdata,
    output logic [SER_W-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [SER_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wptr_r;
    logic [AW-1:0]    rptr_r;
    logic [AW:0]      level_r;
    logic             push_s;
    logic             pop_s;

    assign push_s = push && !full;
    assign pop_s  = pop && !empty;
    assign full   = (level_r == (AW+1)'(DEPTH));
    assign empty  = (level_r == (AW+1)'(0));
    assign level  = level_r;
    assign rdata  = mem_r[rptr_r];

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wptr_r] <= wdata;
        end
    end

    // Pointers wrap naturally at DEPTH; simultaneous push and pop keep level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_r  <= AW'(0);
            rptr_r  <= AW'(0);
            level_r <= (AW+1)'(0);
        end else begin
            if (push_s) begin
                wptr_r <= wptr_r + AW'(1);
            end
            if (pop_s) begin
                rptr_r <= rptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + (AW+1)'(1);
                2'b01:   level_r <= level_r - (AW+1)'(1);
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/seq_ser_tx.sv
// Byte-to-serial transmitter, MSB first, back-to-back bytes without gap bits.
// Optional idle-cycle counter enabled by defining SEQ_SER_UNDERRUN_CNT_EN.
module seq_ser_tx
    import seq_det_pkg::*;
#(
    parameter int   DEPTH    = 4,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    seq_ser_tx_if.slave            in_if,
    output logic                   ser_data,
    output logic                   ser_valid,
    output logic [$clog2(DEPTH):0] fifo_level
`ifdef SEQ_SER_UNDERRUN_CNT_EN
    ,
    output logic [15:0]            underrun_cnt
`endif
);
    t_ser_state       state_r, state_s;
    logic [SER_W-1:0] sr_r, sr_s;
    logic [2:0]       bit_cnt_r, bit_cnt_s;
    logic [SER_W-1:0] head_s;
    logic             push_s, pop_s, full_s, empty_s;
    logic             rdy_en_r;
    logic             ser_data_r, ser_valid_r;

    // rdy_en_r keeps in_ready low through reset and until the first released edge.
    assign in_if.in_ready = rdy_en_r && !full_s;
    assign push_s         = in_if.in_valid && in_if.in_ready;
    assign ser_data       = ser_data_r;
    assign ser_valid      = ser_valid_r;

    seq_ser_fifo #(.DEPTH(DEPTH), .SER_W(SER_W)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (in_if.in_data),
        .rdata (head_s),
        .full  (full_s),
        .empty (empty_s),
        .level (fifo_level)
    );

    // Next-state: load from FIFO head when idle or on the last bit of a byte.
    always_comb begin
        state_s   = state_r;
        sr_s      = sr_r;
        bit_cnt_s = bit_cnt_r;
        pop_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (!empty_s) begin
                    pop_s     = 1'b1;
                    sr_s      = head_s;
                    bit_cnt_s = 3'd0;
                    state_s   = SHIFT;
                end else begin
                    state_s   = IDLE;
                end
            end
            SHIFT: begin
                if (bit_cnt_r == 3'd7 && !empty_s) begin
                    pop_s     = 1'b1;
                    sr_s      = head_s;
                    bit_cnt_s = 3'd0;
                end else if (bit_cnt_r == 3'd7) begin
                    sr_s      = {sr_r[SER_W-2:0], 1'b0};
                    bit_cnt_s = 3'd0;
                    state_s   = IDLE;
                end else begin
                    sr_s      = {sr_r[SER_W-2:0], 1'b0};
                    bit_cnt_s = bit_cnt_r + 3'd1;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, shift register and registered serial outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            sr_r        <= {SER_W{1'b0}};
            bit_cnt_r   <= 3'd0;
            rdy_en_r    <= 1'b0;
            ser_valid_r <= 1'b0;
            ser_data_r  <= IDLE_BIT;
        end else begin
            state_r     <= state_s;
            sr_r        <= sr_s;
            bit_cnt_r   <= bit_cnt_s;
            rdy_en_r    <= 1'b1;
            ser_valid_r <= (state_s == SHIFT);
            ser_data_r  <= (state_s == SHIFT) ? sr_s[SER_W-1] : IDLE_BIT;
        end
    end

`ifdef SEQ_SER_UNDERRUN_CNT_EN
    logic        seen_r;
    logic [15:0] urun_r;

    assign underrun_cnt = urun_r;

    // Saturating count of idle cycles once any byte has been accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seen_r <= 1'b0;
            urun_r <= 16'd0;
        end else begin
            if (push_s) begin
                seen_r <= 1'b1;
            end
            if (seen_r && state_r == IDLE && urun_r != 16'hFFFF) begin
                urun_r <= urun_r + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_seq_ser_tx.sv
// Directed and random stimulus for seq_ser_tx against a queue-based bit-stream model.
module tb_seq_ser_tx;
    import seq_det_pkg::*;

    localparam int   DEPTH    = 4;
    localparam logic IDLE_BIT = 1'b0;
    localparam int   LW       = $clog2(DEPTH) + 1;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          ser_data;
    logic          ser_valid;
    logic [LW-1:0] fifo_level;
`ifdef SEQ_SER_UNDERRUN_CNT_EN
    logic [15:0]   underrun_cnt;
`endif

    seq_ser_tx_if bus ();

    always #5 clk = ~clk;

    seq_ser_tx #(.DEPTH(DEPTH), .IDLE_BIT(IDLE_BIT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_if      (bus),
        .ser_data   (ser_data),
        .ser_valid  (ser_valid),
        .fifo_level (fifo_level)
`ifdef SEQ_SER_UNDERRUN_CNT_EN
        ,
        .underrun_cnt (underrun_cnt)
`endif
    );

    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model: queued bytes, bits still to emit, handshake and idle count.
    logic [7:0] mq[$];
    logic       mbits[$];
    logic       m_ready = 1'b0;
    logic       m_acc   = 1'b0;
    logic       m_seen  = 1'b0;
    int         m_urun  = 0;
    logic       cap[$];
    logic [7:0] exp_b[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic       was_idle;
        logic [7:0] b;
        m_acc = 1'b0;
        if (!rst_n) begin
            mq.delete();
            mbits.delete();
            m_ready = 1'b0;
            m_seen  = 1'b0;
            m_urun  = 0;
        end else begin
            m_acc    = bus.in_valid && m_ready;
            was_idle = (mbits.size() == 0);
            if (m_seen && was_idle && m_urun < 65535) m_urun++;
            if (!was_idle) void'(mbits.pop_front());
            if (mbits.size() == 0 && mq.size() != 0) begin
                b = mq.pop_front();
                for (int i = 7; i >= 0; i--) mbits.push_back(b[i]);
            end
            if (m_acc) begin
                mq.push_back(bus.in_data);
                m_seen = 1'b1;
            end
            m_ready = (mq.size() < DEPTH);
        end
    endtask

    task automatic check_cycle();
        logic exp_v;
        exp_v = (mbits.size() != 0);
        chk("ser_valid", ser_valid, exp_v);
        chk("ser_data", ser_data, exp_v ? mbits[0] : IDLE_BIT);
        chk("in_ready", bus.in_ready, m_ready);
        chk("fifo_level", fifo_level, mq.size());
`ifdef SEQ_SER_UNDERRUN_CNT_EN
        chk("underrun_cnt", underrun_cnt, m_urun);
`endif
        if (ser_valid === 1'b1) cap.push_back(ser_data);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_cycle();
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        do begin
            step();
            n++;
        end while (!m_acc && n < 50);
        chk("send_accepted", m_acc, 1'b1);
        bus.in_valid = 1'b0;
    endtask

    initial begin
        logic [7:0]  d;
        logic [15:0] pat;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        chk("ready_after_reset", bus.in_ready, 1'b1);

        // single byte, MSB first
        cap.delete();
        d = 8'b10011001;
        send(d);
        repeat (12) step();
        chk("single_len", cap.size(), 8);
        for (int i = 0; i < 8 && i < cap.size(); i++) chk("single_bit", cap[i], d[7-i]);

        // back-to-back bytes form one contiguous 16-bit burst
        cap.delete();
        pat = 16'b1010010100111100;
        send(8'hA5);
        send(8'h3C);
        repeat (20) step();
        chk("b2b_len", cap.size(), 16);
        for (int i = 0; i < 16 && i < cap.size(); i++) chk("b2b_bit", cap[i], pat[15-i]);

        // fill past DEPTH: ready drops after the fifth acceptance
        cap.delete();
        exp_b.delete();
        for (int k = 0; k < 6; k++) begin
            d = 8'($urandom_range(0, 255));
            exp_b.push_back(d);
            send(d);
            if (k == 4) chk("full_ready_low", bus.in_ready, 1'b0);
        end
        repeat (60) step();
        chk("fill_len", cap.size(), 48);
        for (int i = 0; i < 48 && i < cap.size(); i++) chk("fill_bit", cap[i], exp_b[i/8][7-(i%8)]);

        // random traffic at several offered loads; producer holds data until accepted
        for (int seg = 0; seg < 3; seg++) begin
            for (int c = 0; c < 150; c++) begin
                if (bus.in_valid !== 1'b1 || m_acc) begin
                    bus.in_valid = ($urandom_range(0, 99) < 20 + 40 * seg);
                    bus.in_data  = 8'($urandom_range(0, 255));
                end
                step();
            end
        end
        bus.in_valid = 1'b0;
        repeat (60) step();

        // reset in the middle of a byte with two more queued
        send(8'hFF);
        send(8'h11);
        send(8'h22);
        step();
        rst_n = 1'b0;
        step();
        chk("rst_ser_valid", ser_valid, 1'b0);
        chk("rst_fifo_level", fifo_level, 0);
        rst_n = 1'b1;
        cap.delete();
        repeat (20) step();
        chk("no_residual_bits", cap.size(), 0);

`ifdef SEQ_SER_UNDERRUN_CNT_EN
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        send(8'h5A);
        repeat (20) step();
        chk("underrun_12", underrun_cnt, 16'd12);
        repeat (70000) step();
        chk("underrun_sat", underrun_cnt, 16'hFFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seq_ser_tx.md
SEQ_SER_TX -- requirements
Module: seq_ser_tx

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the byte FIFO depth; legal values are powers of two, 2..16.
REQ-002 Parameter IDLE_BIT, default 1'b0, SHALL set the ser_data level driven when no byte is being shifted.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  SHALL be the reset, synchronous and active-low.
REQ-005 in_data  input  8  SHALL carry the parallel byte to serialize.
REQ-006 in_valid  input  1  SHALL qualify in_data.
REQ-007 in_ready  output  1  SHALL indicate a byte can be accepted.
REQ-008 ser_data  output  1  SHALL be the serial bit stream, one bit per clk, feeding the sequence detector's ser_data.
REQ-009 ser_valid  output  1  SHALL be high when ser_data carries a payload bit.
REQ-010 fifo_level  output  $clog2(DEPTH)+1  SHALL report the current FIFO occupancy.

Function
REQ-011 A byte SHALL be accepted on a posedge where in_valid && in_ready; in_ready = !full, and is 0 while rst_n is low.
REQ-012 in_data SHALL be ignored when in_valid is low or in_ready is low; the producer holds in_data until acceptance.
REQ-013 The FSM SHALL have states IDLE and SHIFT; reset state IDLE.
REQ-014 IDLE: if the FIFO is non-empty, pop the head into an 8-bit shift register, clear bit_cnt to 0, and go to SHIFT; otherwise stay.
REQ-015 SHIFT: ser_data = sr[7] and ser_valid = 1; each clk, shift sr left and increment bit_cnt.
REQ-016 SHIFT with bit_cnt==7: if the FIFO is non-empty, pop and load the next byte in the same edge and stay in SHIFT with no gap bit; otherwise go to IDLE.
REQ-017 Bit order SHALL be MSB first.
REQ-018 In IDLE, ser_data SHALL be IDLE_BIT and ser_valid 0.
REQ-019 Latency: for a byte accepted at edge k into an empty FIFO with the FSM in IDLE, its bit 7 SHALL appear in the cycle after edge k+1.
REQ-020 A push and a pop on the same edge SHALL leave fifo_level unchanged and lose no data.
REQ-021 When full, in_ready SHALL be 0; a pop on that edge frees a slot, and in_ready rises in the next cycle.
REQ-022 FIFO read and write pointers SHALL wrap modulo DEPTH; fifo_level SHALL never exceed DEPTH or underflow.

Reset
REQ-023 While rst_n is low at a posedge, the block SHALL set: state IDLE, FIFO empty (fifo_level 0), sr 0, bit_cnt 0, ser_valid 0, ser_data IDLE_BIT, in_ready 0.
REQ-024 A reset mid-byte SHALL discard the partial byte and all FIFO contents; no residual bits SHALL be emitted after reset releases.
REQ-025 in_ready SHALL be 1 in the first cycle after rst_n is sampled high.

Configuration
REQ-026 When macro SEQ_SER_UNDERRUN_CNT_EN is defined, the block SHALL add output underrun_cnt [15:0].
- underrun_cnt counts every IDLE cycle that follows the first accepted byte since reset.
- The count saturates at 16'hFFFF.
- Reset clears it to 0.
REQ-027 When SEQ_SER_UNDERRUN_CNT_EN is undefined, the port and the counter SHALL be absent; all other behaviour is identical.

Structure
REQ-028 Package seq_det_pkg SHALL hold:
- typedef t_ser_state {IDLE, SHIFT};
- constant SER_W = 8.
REQ-029 The FIFO SHALL be a separate sub-module, seq_ser_fifo, parameterized by DEPTH and SER_W, with push, pop, full, empty and level.

Verification
REQ-030 Single byte: reset, push 8'b10011001 at edge 0 -> ser_data 1,0,0,1,1,0,0,1 in cycles 2..9 with ser_valid high, then IDLE_BIT; the downstream detector asserts seq_detected.
REQ-031 Back-to-back: push 8'hA5 then 8'h3C on consecutive edges -> 16 contiguous bits 1010010100111100 with ser_valid never dropping.
REQ-032 Fill, DEPTH=4: push 6 bytes on consecutive edges -> in_ready falls after the 5th acceptance; the 6th byte is accepted only after the next pop; all 48 bits are emitted in order.
REQ-033 Reset mid-byte: assert rst_n low during bit 3 of 8'hFF with 2 bytes queued -> ser_valid 0 and fifo_level 0 after the reset edge; only IDLE_BIT is emitted afterwards.
REQ-034 SEQ_SER_UNDERRUN_CNT_EN defined: push 1 byte, then wait 20 cycles -> underrun_cnt = 12 at the end of that window; force 70000 idle cycles -> underrun_cnt holds at 16'hFFFF.
